// File: rtl/fadsu_pkg.sv
// Shared types and constants for the digit-serial add/subtract controller.
`timescale 1ns/1ps
package fadsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic CON_ADD = 1'b1;
  localparam logic CON_SUB = 1'b0;

  // Digit counter width: enough bits to count 0..n-1, never narrower than 1.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fadsu_digit_serial_if.sv
// Request/result bundle between a client and the digit-serial controller.
`timescale 1ns/1ps
interface fadsu_digit_serial_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic             CON;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] S;
  logic             BCO;
  logic             OVF;

  modport master (
    output START, CON, A, B,
    input  BUSY, DONE, S, BCO, OVF
  );

  modport slave (
    input  START, CON, A, B,
    output BUSY, DONE, S, BCO, OVF
  );
endinterface

// File: rtl/fadsu_slice2.sv
// Combinational 2-bit add/subtract digit; CON=1 adds B, CON=0 adds ~B.
`timescale 1ns/1ps
module fadsu_slice2 (
  input  logic A0,
  input  logic A1,
  input  logic B0,
  input  logic B1,
  input  logic BCI,
  input  logic CON,
  output logic S0,
  output logic S1,
  output logic BCO
);
  logic b0p, b1p, c1;

  // Two ripple full-adder bits with B conditionally inverted by CON.
  always_comb begin
    b0p = ~(B0 ^ CON);
    b1p = ~(B1 ^ CON);
    S0  = A0 ^ b0p ^ BCI;
    c1  = (A0 & b0p) | (A0 & BCI) | (b0p & BCI);
    S1  = A1 ^ b1p ^ c1;
    BCO = (A1 & b1p) | (A1 & c1) | (b1p & c1);
  end
endmodule

// File: rtl/fadsu_digit_serial.sv
// Digit-serial add/subtract controller: two bits per cycle, LSB digit first,
// carry registered between digits; result published with a one-cycle DONE.
`timescale 1ns/1ps
module fadsu_digit_serial
  import fadsu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                CK,
  input  logic                LSR,
  fadsu_digit_serial_if.slave bus
);
  localparam int N  = WIDTH / 2;
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             cy_q;
  logic             con_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [WIDTH-1:0] s_q;
  logic             bco_q, ovf_q;

  logic             accept, run, last;
  logic             sl_s0, sl_s1, sl_bco;
  logic             b_msb_eff, ovf_d;
  logic [WIDTH-1:0] dig_w, res_next;

  // Only the low digit of each operand shift register feeds the slice.
  fadsu_slice2 u_slice (
    .A0  (a_sh[0]),
    .A1  (a_sh[1]),
    .B0  (b_sh[0]),
    .B1  (b_sh[1]),
    .BCI (cy_q),
    .CON (con_q),
    .S0  (sl_s0),
    .S1  (sl_s1),
    .BCO (sl_bco)
  );

  // Handshake decode, result assembly and last-digit overflow detection.
  always_comb begin
    accept    = bus.START && (state_q != RUN);
    run       = (state_q == RUN);
    last      = run && (cnt_q == LAST);
    dig_w     = WIDTH'({sl_s1, sl_s0});
    res_next  = (res_sh >> 2) | (dig_w << (WIDTH - 2));
    b_msb_eff = ~(b_sh[1] ^ con_q);
    ovf_d     = (a_sh[1] == b_msb_eff) && (sl_s1 != a_sh[1]);
  end

  // State register.
  always_ff @(posedge CK) begin
    if (LSR) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; START in RUN is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.START) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = bus.START ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: counter, inter-digit carry and published result.
  always_ff @(posedge CK) begin
    if (LSR) begin
      cnt_q <= '0;
      cy_q  <= 1'b0;
      s_q   <= '0;
      bco_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      cy_q  <= ~bus.CON;
    end else if (run) begin
      cnt_q <= cnt_q + CW'(1);
      cy_q  <= sl_bco;
      if (last) begin
        s_q   <= res_next;
        bco_q <= sl_bco;
        ovf_q <= ovf_d;
      end
    end
  end

  // Operand and partial-result shift registers; contents are don't-care
  // outside RUN, so they carry no reset.
  always_ff @(posedge CK) begin
    if (accept) begin
      a_sh  <= bus.A;
      b_sh  <= bus.B;
      con_q <= bus.CON;
    end else if (run) begin
      a_sh   <= a_sh >> 2;
      b_sh   <= b_sh >> 2;
      res_sh <= res_next;
    end
  end

  assign bus.BUSY = (state_q == RUN);
  assign bus.DONE = (state_q == DONE);
  assign bus.S    = s_q;
  assign bus.BCO  = bco_q;
  assign bus.OVF  = ovf_q;

endmodule

// File: tb/tb_fadsu_digit_serial.sv
// Randomized and directed bench for fadsu_digit_serial (WIDTH=8 and WIDTH=2).
`timescale 1ns/1ps
module tb_fadsu_digit_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fadsu_digit_serial_if #(.WIDTH(8)) bus8 ();
  fadsu_digit_serial_if #(.WIDTH(2)) bus2 ();

  fadsu_digit_serial #(.WIDTH(8)) dut8 (.CK(clk), .LSR(rst), .bus(bus8.slave));
  fadsu_digit_serial #(.WIDTH(2)) dut2 (.CK(clk), .LSR(rst), .bus(bus2.slave));

  // Behavioural model: plain integer arithmetic on a w-bit operation.
  function automatic void ref_op(input int w, input int a, input int b, input bit con,
                                 output int s, output bit bco, output bit ovf);
    int mask, full;
    bit sa, sb, ss;
    mask = (1 << w) - 1;
    if (con) begin
      full = a + b;
      s    = full & mask;
      bco  = ((full >> w) & 1) != 0;
    end else begin
      s    = (a - b) & mask;
      bco  = (a >= b);
    end
    sa  = ((a >> (w - 1)) & 1) != 0;
    sb  = ((b >> (w - 1)) & 1) != 0;
    ss  = ((s >> (w - 1)) & 1) != 0;
    ovf = con ? ((sa == sb) && (ss != sa)) : ((sa != sb) && (ss != sa));
  endfunction

  // Present a request just after an edge; it is accepted on the next edge.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic con);
    bus8.START = 1'b1;
    bus8.A     = a;
    bus8.B     = b;
    bus8.CON   = con;
    @(posedge clk); #1;
    bus8.START = 1'b0;
    bus8.A     = 8'($urandom);
    bus8.B     = 8'($urandom);
    bus8.CON   = 1'($urandom);
  endtask

  // Follow an accepted request to DONE and compare against the model.
  task automatic wait8(input logic [7:0] a, input logic [7:0] b, input logic con,
                       input bit hold, input logic [7:0] old_s, input bit poke,
                       input string tag);
    int  es, cyc;
    bit  ebco, eovf;
    ref_op(8, int'(a), int'(b), con, es, ebco, eovf);
    checks++;
    if (bus8.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_accept: got %b want 1", tag, bus8.BUSY);
    end
    cyc = 0;
    while (cyc < 12) begin
      if (hold) begin
        checks++;
        if (bus8.S !== old_s) begin
          errors++;
          $display("FAIL %s hold_s: got %h want %h", tag, bus8.S, old_s);
        end
      end
      if (poke) begin
        bus8.START = 1'($urandom);
        bus8.A     = 8'($urandom);
        bus8.B     = 8'($urandom);
        bus8.CON   = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (bus8.DONE) break;
    end
    bus8.START = 1'b0;
    checks++;
    if (cyc != 4 || bus8.DONE !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles done=%b want 4 cycles", tag, cyc, bus8.DONE);
    end
    checks++;
    if (bus8.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_with_done: got %b want 0", tag, bus8.BUSY);
    end
    checks++;
    if (bus8.S !== 8'(es)) begin
      errors++;
      $display("FAIL %s s: got %h want %h", tag, bus8.S, 8'(es));
    end
    checks++;
    if (bus8.BCO !== ebco) begin
      errors++;
      $display("FAIL %s bco: got %b want %b", tag, bus8.BCO, ebco);
    end
    checks++;
    if (bus8.OVF !== eovf) begin
      errors++;
      $display("FAIL %s ovf: got %b want %b", tag, bus8.OVF, eovf);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic con,
                     input string tag);
    @(posedge clk); #1;
    launch8(a, b, con);
    wait8(a, b, con, 1'b0, 8'h00, 1'b0, tag);
  endtask

  task automatic check_idle8(input string tag);
    checks++;
    if ({bus8.BUSY, bus8.DONE, bus8.S, bus8.BCO, bus8.OVF} !== 12'h000) begin
      errors++;
      $display("FAIL %s outputs: got busy=%b done=%b s=%h bco=%b ovf=%b want all 0",
               tag, bus8.BUSY, bus8.DONE, bus8.S, bus8.BCO, bus8.OVF);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.START = 1'b0; bus8.A = '0; bus8.B = '0; bus8.CON = 1'b0;
    bus2.START = 1'b0; bus2.A = '0; bus2.B = '0; bus2.CON = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle8("reset8");
    checks++;
    if ({bus2.BUSY, bus2.DONE, bus2.S, bus2.BCO, bus2.OVF} !== 6'h00) begin
      errors++;
      $display("FAIL reset2 outputs: got busy=%b done=%b s=%h bco=%b ovf=%b want all 0",
               bus2.BUSY, bus2.DONE, bus2.S, bus2.BCO, bus2.OVF);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    op8(8'h5A, 8'h33, fadsu_pkg::CON_ADD, "add_5a_33");
    op8(8'h10, 8'h20, fadsu_pkg::CON_SUB, "sub_borrow");
    op8(8'h80, 8'h01, fadsu_pkg::CON_SUB, "sub_ovf");
  endtask

  task automatic test_back_to_back();
    op8(8'hFF, 8'h01, fadsu_pkg::CON_ADD, "wrap");
    launch8(8'h03, 8'h02, fadsu_pkg::CON_SUB);
    wait8(8'h03, 8'h02, fadsu_pkg::CON_SUB, 1'b1, 8'h00, 1'b0, "b2b_second");
    for (int i = 0; i < 6; i++) begin
      logic [7:0] a, b, prev;
      logic       c;
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      prev = bus8.S;
      launch8(a, b, c);
      wait8(a, b, c, 1'b1, prev, 1'b0, "b2b_rand");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [7:0] a, b;
      logic       c;
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      op8(a, b, c, "rand");
    end
  endtask

  task automatic test_start_during_run();
    for (int i = 0; i < 5; i++) begin
      logic [7:0] a, b;
      logic       c;
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      @(posedge clk); #1;
      launch8(a, b, c);
      wait8(a, b, c, 1'b0, 8'h00, 1'b1, "start_in_run");
    end
  endtask

  task automatic test_reset_midrun();
    op8(8'h5A, 8'h33, fadsu_pkg::CON_ADD, "pre_reset");
    @(posedge clk); #1;
    launch8(8'h12, 8'h34, fadsu_pkg::CON_ADD);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle8("reset_midrun");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus8.DONE !== 1'b0 || bus8.BUSY !== 1'b0) begin
        errors++;
        $display("FAIL reset_midrun_quiet: got busy=%b done=%b want 0 0", bus8.BUSY, bus8.DONE);
      end
    end
    op8(8'h12, 8'h34, fadsu_pkg::CON_ADD, "after_reset");
  endtask

  task automatic test_reset_vs_start();
    @(posedge clk); #1;
    rst = 1'b1;
    bus8.START = 1'b1; bus8.A = 8'h11; bus8.B = 8'h22; bus8.CON = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus8.START = 1'b0;
    check_idle8("rst_start_same");
    repeat (2) @(posedge clk);
    #1;
    check_idle8("rst_start_stays_idle");
  endtask

  task automatic test_width2();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++) begin
          int es;
          bit ebco, eovf;
          ref_op(2, a, b, c[0], es, ebco, eovf);
          @(posedge clk); #1;
          bus2.START = 1'b1; bus2.A = 2'(a); bus2.B = 2'(b); bus2.CON = c[0];
          @(posedge clk); #1;
          bus2.START = 1'b0; bus2.A = 2'($urandom); bus2.B = 2'($urandom);
          checks++;
          if (bus2.BUSY !== 1'b1 || bus2.DONE !== 1'b0) begin
            errors++;
            $display("FAIL w2_busy a=%0d b=%0d c=%0d: got busy=%b done=%b want 1 0",
                     a, b, c, bus2.BUSY, bus2.DONE);
          end
          @(posedge clk); #1;
          checks++;
          if (bus2.DONE !== 1'b1 || bus2.BUSY !== 1'b0 || bus2.S !== 2'(es) ||
              bus2.BCO !== ebco || bus2.OVF !== eovf) begin
            errors++;
            $display("FAIL w2_result a=%0d b=%0d c=%0d: got done=%b busy=%b s=%h bco=%b ovf=%b want 1 0 %h %b %b",
                     a, b, c, bus2.DONE, bus2.BUSY, bus2.S, bus2.BCO, bus2.OVF,
                     2'(es), ebco, eovf);
          end
        end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_start_during_run();
    test_reset_midrun();
    test_reset_vs_start();
    test_width2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
